// File: rtl/radio_enable_sequencer_if.sv
// Radio control handshake between the S2->S3 crossing and the enable sequencer.
interface radio_enable_sequencer_if;
    logic isolateM1M2;
    logic radioEnable1;
    logic radioRxEn1;
    logic ldoEn;
    logic pllEn;
    logic rxEn;
    logic txEn;
    logic radioReady;
    logic seqBusy;
    logic abortPulse;

    // Requester side: drives the level requests and observes the rail enables.
    modport master (
        output isolateM1M2,
        output radioEnable1,
        output radioRxEn1,
        input  ldoEn,
        input  pllEn,
        input  rxEn,
        input  txEn,
        input  radioReady,
        input  seqBusy,
        input  abortPulse
    );

    // Sequencer side.
    modport slave (
        input  isolateM1M2,
        input  radioEnable1,
        input  radioRxEn1,
        output ldoEn,
        output pllEn,
        output rxEn,
        output txEn,
        output radioReady,
        output seqBusy,
        output abortPulse
    );
endinterface

// File: rtl/radio_enable_sequencer.sv
// Radio power sequencer: orders LDO, PLL and RX/TX enables from level requests,
// handles RX/TX turnaround, aborted power-ups and isolation.
module radio_enable_sequencer #(
    parameter int unsigned LDO_CYCLES    = 4,
    parameter int unsigned SETTLE_CYCLES = 16,
    parameter int unsigned TURN_CYCLES   = 2,
    parameter int unsigned RAMPDN_CYCLES = 4,
    parameter int unsigned CNT_W         = 8
) (
    input  logic                    ck,
    input  logic                    arst_n,
    radio_enable_sequencer_if.slave bus
);

    localparam logic [CNT_W-1:0] LDO_LOAD    = CNT_W'(LDO_CYCLES - 1);
    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TURN_LOAD   = CNT_W'(TURN_CYCLES - 1);
    localparam logic [CNT_W-1:0] RAMPDN_LOAD = CNT_W'(RAMPDN_CYCLES - 1);

    typedef enum logic [2:0] {
        S_OFF      = 3'd0,
        S_LDO_UP   = 3'd1,
        S_PLL_LOCK = 3'd2,
        S_ACTIVE   = 3'd3,
        S_TURN     = 3'd4,
        S_RAMP_DN  = 3'd5
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             mode;
    logic             mode_nxt;
    logic             en_eff;

    logic ldo_en,  ldo_en_nxt;
    logic pll_en,  pll_en_nxt;
    logic rx_en,   rx_en_nxt;
    logic tx_en,   tx_en_nxt;
    logic ready,   ready_nxt;
    logic busy,    busy_nxt;
    logic abort,   abort_nxt;

    // Isolation masks the request; inputs are already synchronous to ck.
    assign en_eff = bus.radioEnable1 & ~bus.isolateM1M2;

    // Next-state, counter, mode latch and next-output decode.
    always_comb begin
        state_nxt  = state;
        cnt_nxt    = (cnt != '0) ? cnt - CNT_W'(1) : cnt;
        mode_nxt   = mode;
        abort_nxt  = 1'b0;

        unique case (state)
            S_OFF: begin
                if (en_eff) begin
                    state_nxt = S_LDO_UP;
                    cnt_nxt   = LDO_LOAD;
                    mode_nxt  = bus.radioRxEn1;
                end
            end
            S_LDO_UP: begin
                if (!en_eff) begin
                    state_nxt = S_RAMP_DN;
                    cnt_nxt   = RAMPDN_LOAD;
                    abort_nxt = 1'b1;
                end else if (cnt == '0) begin
                    state_nxt = S_PLL_LOCK;
                    cnt_nxt   = SETTLE_LOAD;
                end
            end
            S_PLL_LOCK: begin
                if (!en_eff) begin
                    state_nxt = S_RAMP_DN;
                    cnt_nxt   = RAMPDN_LOAD;
                    abort_nxt = 1'b1;
                end else if (cnt == '0) begin
                    state_nxt = S_ACTIVE;
                    cnt_nxt   = '0;
                    mode_nxt  = bus.radioRxEn1;
                end
            end
            S_ACTIVE: begin
                // Drop wins over a simultaneous mode change.
                if (!en_eff) begin
                    state_nxt = S_RAMP_DN;
                    cnt_nxt   = RAMPDN_LOAD;
                end else if (bus.radioRxEn1 != mode) begin
                    state_nxt = S_TURN;
                    cnt_nxt   = TURN_LOAD;
                end
            end
            S_TURN: begin
                if (!en_eff) begin
                    state_nxt = S_RAMP_DN;
                    cnt_nxt   = RAMPDN_LOAD;
                end else if (cnt == '0) begin
                    state_nxt = S_ACTIVE;
                    mode_nxt  = bus.radioRxEn1;
                end
            end
            S_RAMP_DN: begin
                // Ramp-down always runs to completion.
                if (cnt == '0) begin
                    state_nxt = S_OFF;
                end
            end
            default: begin
                state_nxt = S_OFF;
                cnt_nxt   = '0;
            end
        endcase

        // Outputs follow the next state so they switch on the same edge.
        ldo_en_nxt = 1'b0;
        pll_en_nxt = 1'b0;
        rx_en_nxt  = 1'b0;
        tx_en_nxt  = 1'b0;
        ready_nxt  = 1'b0;
        busy_nxt   = 1'b0;
        unique case (state_nxt)
            S_LDO_UP: begin
                ldo_en_nxt = 1'b1;
                busy_nxt   = 1'b1;
            end
            S_PLL_LOCK: begin
                ldo_en_nxt = 1'b1;
                pll_en_nxt = 1'b1;
                busy_nxt   = 1'b1;
            end
            S_ACTIVE: begin
                ldo_en_nxt = 1'b1;
                pll_en_nxt = 1'b1;
                ready_nxt  = 1'b1;
                rx_en_nxt  = mode_nxt;
                tx_en_nxt  = ~mode_nxt;
            end
            S_TURN: begin
                ldo_en_nxt = 1'b1;
                pll_en_nxt = 1'b1;
                busy_nxt   = 1'b1;
            end
            S_RAMP_DN: begin
                ldo_en_nxt = 1'b1;
                busy_nxt   = 1'b1;
            end
            default: begin
                ldo_en_nxt = 1'b0;
            end
        endcase
    end

    // State, counter, mode and registered outputs.
    always_ff @(posedge ck or negedge arst_n) begin
        if (!arst_n) begin
            state  <= S_OFF;
            cnt    <= '0;
            mode   <= 1'b1;
            ldo_en <= 1'b0;
            pll_en <= 1'b0;
            rx_en  <= 1'b0;
            tx_en  <= 1'b0;
            ready  <= 1'b0;
            busy   <= 1'b0;
            abort  <= 1'b0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            mode   <= mode_nxt;
            ldo_en <= ldo_en_nxt;
            pll_en <= pll_en_nxt;
            rx_en  <= rx_en_nxt;
            tx_en  <= tx_en_nxt;
            ready  <= ready_nxt;
            busy   <= busy_nxt;
            abort  <= abort_nxt;
        end
    end

    assign bus.ldoEn      = ldo_en;
    assign bus.pllEn      = pll_en;
    assign bus.rxEn       = rx_en;
    assign bus.txEn       = tx_en;
    assign bus.radioReady = ready;
    assign bus.seqBusy    = busy;
    assign bus.abortPulse = abort;

endmodule

// File: tb/tb_radio_enable_sequencer.sv
// Scoreboard bench for radio_enable_sequencer: directed plan scenarios then random traffic.
module tb_radio_enable_sequencer;

    localparam int LDO_N    = 4;
    localparam int SETTLE_N = 16;
    localparam int TURN_N   = 2;
    localparam int RAMPDN_N = 4;

    // Reference model phases.
    localparam int PH_OFF = 0, PH_LDO = 1, PH_PLL = 2, PH_ACT = 3, PH_TURN = 4, PH_RAMP = 5;

    logic ck;
    logic arst_n;
    radio_enable_sequencer_if bus ();

    radio_enable_sequencer #(
        .LDO_CYCLES    (LDO_N),
        .SETTLE_CYCLES (SETTLE_N),
        .TURN_CYCLES   (TURN_N),
        .RAMPDN_CYCLES (RAMPDN_N),
        .CNT_W         (8)
    ) dut (
        .ck     (ck),
        .arst_n (arst_n),
        .bus    (bus)
    );

    int chk_total = 0;
    int chk_pass  = 0;
    bit check_en  = 1'b0;

    // Expected {ldo, pll, rx, tx, ready, busy, abort} per clock edge.
    logic [6:0] exp_q[$];

    int m_phase;
    int m_spent;
    bit m_mode;
    bit m_abort;

    initial ck = 1'b0;
    always #5 ck = ~ck;

    function automatic logic [6:0] dut_outs();
        return {bus.ldoEn, bus.pllEn, bus.rxEn, bus.txEn,
                bus.radioReady, bus.seqBusy, bus.abortPulse};
    endfunction

    function automatic int phase_len(input int ph);
        case (ph)
            PH_LDO:  return LDO_N;
            PH_PLL:  return SETTLE_N;
            PH_TURN: return TURN_N;
            PH_RAMP: return RAMPDN_N;
            default: return 0;
        endcase
    endfunction

    task automatic check(input string name, input logic [6:0] got, input logic [6:0] want);
        chk_total++;
        if (got === want) chk_pass++;
        else $display("FAIL %s at %0t: got %b expected %b", name, $time, got, want);
    endtask

    task automatic model_reset();
        m_phase = PH_OFF;
        m_spent = 0;
        m_mode  = 1'b1;
        m_abort = 1'b0;
    endtask

    task automatic goto(input int ph);
        m_phase = ph;
        m_spent = 0;
    endtask

    // One clock edge of the reference behaviour given the inputs held across it.
    task automatic model_step(input bit en, input bit rx);
        bit done;
        done    = (m_spent + 1 >= phase_len(m_phase));
        m_abort = 1'b0;
        case (m_phase)
            PH_OFF:  if (en) begin goto(PH_LDO); m_mode = rx; end
            PH_LDO:  if (!en) begin goto(PH_RAMP); m_abort = 1'b1; end
                     else if (done) goto(PH_PLL);
                     else m_spent++;
            PH_PLL:  if (!en) begin goto(PH_RAMP); m_abort = 1'b1; end
                     else if (done) begin goto(PH_ACT); m_mode = rx; end
                     else m_spent++;
            PH_ACT:  if (!en) goto(PH_RAMP);
                     else if (rx != m_mode) goto(PH_TURN);
            PH_TURN: if (!en) goto(PH_RAMP);
                     else if (done) begin goto(PH_ACT); m_mode = rx; end
                     else m_spent++;
            default: if (done) goto(PH_OFF);
                     else m_spent++;
        endcase
    endtask

    function automatic logic [6:0] model_outs();
        bit act;
        act = (m_phase == PH_ACT);
        return {m_phase != PH_OFF,
                m_phase == PH_PLL || act || m_phase == PH_TURN,
                act && m_mode,
                act && !m_mode,
                act,
                m_phase == PH_LDO || m_phase == PH_PLL || m_phase == PH_TURN || m_phase == PH_RAMP,
                m_abort};
    endfunction

    task automatic drive_and_push(input bit en, input bit rx, input bit iso);
        bus.radioEnable1 = en;
        bus.radioRxEn1   = rx;
        bus.isolateM1M2  = iso;
        model_step(en && !iso, rx);
        exp_q.push_back(model_outs());
    endtask

    task automatic cycle(input bit en, input bit rx, input bit iso);
        @(negedge ck);
        drive_and_push(en, rx, iso);
    endtask

    task automatic run(input int n, input bit en, input bit rx, input bit iso);
        for (int i = 0; i < n; i++) cycle(en, rx, iso);
    endtask

    // Mid-cycle asynchronous reset, released on a falling edge with a restart request.
    task automatic async_reset(input bit rx);
        @(posedge ck);
        #3;
        arst_n = 1'b0;
        #1;
        check("async_reset_outputs", dut_outs(), 7'b0);
        model_reset();
        @(negedge ck);
        arst_n = 1'b1;
        drive_and_push(1'b1, rx, 1'b0);
    endtask

    // Monitor: compare every edge's outputs against the scoreboard.
    always begin
        @(posedge ck);
        #1;
        if (check_en) begin
            if (exp_q.size() == 0) begin
                chk_total++;
                $display("FAIL scoreboard_underflow at %0t: got no expectation, required one", $time);
            end else begin
                check("edge_outputs", dut_outs(), exp_q.pop_front());
            end
            if (bus.rxEn && bus.txEn) begin
                chk_total++;
                $display("FAIL rx_tx_exclusive at %0t: got rx=1 tx=1, required not both", $time);
            end
        end
    end

    initial begin
        bit en, rx, iso;
        arst_n           = 1'b0;
        bus.radioEnable1 = 1'b0;
        bus.radioRxEn1   = 1'b1;
        bus.isolateM1M2  = 1'b0;
        model_reset();
        repeat (3) @(negedge ck);
        check("reset_outputs", dut_outs(), 7'b0);
        arst_n   = 1'b1;
        check_en = 1'b1;
        drive_and_push(1'b0, 1'b1, 1'b0);

        // Power-up into RX, then turnaround to TX.
        run(25, 1'b1, 1'b1, 1'b0);
        run(6,  1'b1, 1'b0, 1'b0);
        // Shutdown to OFF.
        run(7,  1'b0, 1'b0, 1'b0);
        // Abort in the middle of PLL settle.
        run(13, 1'b1, 1'b1, 1'b0);
        run(7,  1'b0, 1'b1, 1'b0);
        // Isolation from ACTIVE, re-enabled during ramp-down.
        run(22, 1'b1, 1'b1, 1'b0);
        run(2,  1'b1, 1'b1, 1'b1);
        run(8,  1'b1, 1'b1, 1'b0);
        // Reach ACTIVE TX, then reset asynchronously and restart.
        run(24, 1'b1, 1'b0, 1'b0);
        async_reset(1'b0);
        run(25, 1'b1, 1'b0, 1'b0);

        // Randomised traffic.
        en = 1'b1; rx = 1'b1; iso = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 499) == 0) begin
                async_reset(rx);
            end else begin
                en  = ($urandom_range(0, 15) != 0);
                iso = ($urandom_range(0, 39) == 0);
                if ($urandom_range(0, 9) == 0) rx = ~rx;
                cycle(en, rx, iso);
            end
        end

        @(posedge ck);
        #2;
        check_en = 1'b0;
        chk_total++;
        if (exp_q.size() == 0) chk_pass++;
        else $display("FAIL scoreboard_drain: got %0d pending, required 0", exp_q.size());

        $display("%0d/%0d checks passed", chk_pass, chk_total);
        $finish;
    end

endmodule
